// File: rtl/mul_div_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
// The op_e encoding equals the instruction's funct3 field.
package mul_div_pkg;

   typedef enum logic [2:0] {
      MUL    = 3'd0,
      MULH   = 3'd1,
      MULHSU = 3'd2,
      MULHU  = 3'd3,
      DIV    = 3'd4,
      DIVU   = 3'd5,
      REM    = 3'd6,
      REMU   = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Fill bits, replicated to the register width: quotient on divide-by-zero, remainder on overflow.
   localparam logic DIV0_Q = 1'b1;
   localparam logic OVF_R  = 1'b0;

   function automatic logic is_div(input op_e op);
      return op[2];
   endfunction

   function automatic logic signed_a(input op_e op);
      return op inside {MUL, MULH, MULHSU, DIV, REM};
   endfunction

   function automatic logic signed_b(input op_e op);
      return op inside {MUL, MULH, DIV, REM};
   endfunction

endpackage

// File: rtl/mul_div_step.sv
// One radix-2 iteration on {acc, opnd}: shift-add for multiply, restoring trial subtract for divide.
// Purely combinational; the caller owns the registers and the iteration count.
module mul_div_step #(
   parameter int Width = 32
) (
   input  logic             div_mode,
   input  logic [Width-1:0] acc,
   input  logic [Width-1:0] opnd,
   input  logic [Width-1:0] addend,
   output logic [Width-1:0] acc_next,
   output logic [Width-1:0] opnd_next
);

   logic [Width:0] sum;
   logic [Width:0] shifted;
   logic           fits;

   // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
   always_comb begin
      sum     = {1'b0, acc} + (opnd[0] ? {1'b0, addend} : '0);
      shifted = {acc, opnd[Width-1]};
      fits    = shifted >= {1'b0, addend};
      if (div_mode) begin
         // The partial remainder stays below the divisor, so Width bits always hold it.
         acc_next  = Width'(fits ? shifted - {1'b0, addend} : shifted);
         opnd_next = {opnd[Width-2:0], fits};
      end else begin
         acc_next  = sum[Width:1];
         opnd_next = {sum[0], opnd[Width-1:1]};
      end
   end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit returning its result on a one-cycle register-file write strobe.
// Define MULDIV_EARLY_OUT_EN to let special-case operands skip the iteration loop.
module mul_div_unit
   import mul_div_pkg::*;
#(
   parameter  int RegisterWidth = 32,
   parameter  int NRegisters    = 32,
   localparam int AddrWidth     = $clog2(NRegisters)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  op_e                      op,
   input  logic [RegisterWidth-1:0] rs1Data,
   input  logic [RegisterWidth-1:0] rs2Data,
   input  logic [AddrWidth-1:0]     rdAddr,
   output logic                     busy,
   output logic                     wEn,
   output logic [AddrWidth-1:0]     wAddr,
   output logic [RegisterWidth-1:0] wData
);

   localparam int W          = RegisterWidth;
   localparam int CountWidth = $clog2(W);
   localparam logic [CountWidth-1:0] LastCount = CountWidth'(W - 1);
   localparam logic [W-1:0] MinSigned = {1'b1, {(W-1){1'b0}}};

   state_e                state, state_next;
   logic [CountWidth-1:0] count;
   logic                  accept, last;

   op_e                   op_q;
   logic [AddrWidth-1:0]  addr_q;
   logic [W-1:0]          acc, opnd, addend, result;
   logic                  neg_q, neg_r, special;

   logic                  a_neg, b_neg, div0, ovf, mul_zero, special_in;
   logic [W-1:0]          mag_a, mag_b, special_val;
   logic [W-1:0]          acc_next, opnd_next, quo, rem, final_result;
   logic [2*W-1:0]        prod_raw, prod;

   assign accept = (state == IDLE) && start;
   assign last   = (state == RUN) && (count == LastCount);

   // Operand decode at the accept edge: magnitudes, signs and the results that bypass the loop.
   always_comb begin
      a_neg      = signed_a(op) && rs1Data[W-1];
      b_neg      = signed_b(op) && rs2Data[W-1];
      mag_a      = a_neg ? -rs1Data : rs1Data;
      mag_b      = b_neg ? -rs2Data : rs2Data;
      div0       = is_div(op) && (rs2Data == '0);
      ovf        = (op inside {DIV, REM}) && (rs1Data == MinSigned) && (rs2Data == '1);
      mul_zero   = !is_div(op) && ((rs1Data == '0) || (rs2Data == '0));
      special_in = div0 || ovf || mul_zero;
      special_val = '0;
      if (div0)
         special_val = (op inside {DIV, DIVU}) ? {W{DIV0_Q}} : rs1Data;
      else if (ovf)
         special_val = (op == DIV) ? rs1Data : {W{OVF_R}};
   end

   mul_div_step #(.Width(W)) u_step (
      .div_mode  (is_div(op_q)),
      .acc       (acc),
      .opnd      (opnd),
      .addend    (addend),
      .acc_next  (acc_next),
      .opnd_next (opnd_next)
   );

   // Sign correction applied to the outcome of the final iteration.
   always_comb begin
      prod_raw = {acc_next, opnd_next};
      prod     = neg_q ? -prod_raw : prod_raw;
      quo      = neg_q ? -opnd_next : opnd_next;
      rem      = neg_r ? -acc_next : acc_next;
      case (op_q)
         MUL:                 final_result = prod[W-1:0];
         MULH, MULHSU, MULHU: final_result = prod[2*W-1:W];
         DIV, DIVU:           final_result = quo;
         default:             final_result = rem;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start) begin
`ifdef MULDIV_EARLY_OUT_EN
            state_next = special_in ? DONE : RUN;
`else
            state_next = RUN;
`endif
         end
         RUN:     if (last) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy  = (state != IDLE);
      wEn   = (state == DONE);
      wAddr = wEn ? addr_q : '0;
      wData = wEn ? result : '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         count <= '0;
      else if (state == RUN)
         count <= last ? '0 : count + CountWidth'(1);
   end

   // Special results are parked in the result register at accept; the loop then leaves it alone.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_q    <= MUL;
         addr_q  <= '0;
         acc     <= '0;
         opnd    <= '0;
         addend  <= '0;
         result  <= '0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         special <= 1'b0;
      end else if (accept) begin
         op_q    <= op;
         addr_q  <= rdAddr;
         acc     <= '0;
         opnd    <= mag_a;
         addend  <= mag_b;
         result  <= special_val;
         neg_q   <= a_neg ^ b_neg;
         neg_r   <= a_neg;
         special <= special_in;
      end else if (state == RUN) begin
         acc  <= acc_next;
         opnd <= opnd_next;
         if (last && !special) result <= final_result;
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed vectors with hand-computed results and write timing.
// Expected latency of special-case operands follows MULDIV_EARLY_OUT_EN.
module tb_mul_div_unit;
   import mul_div_pkg::*;

   localparam int W = 32;
`ifdef MULDIV_EARLY_OUT_EN
   localparam int SPECIAL_DELTA = 0;
`else
   localparam int SPECIAL_DELTA = W;
`endif

   logic        clk = 1'b0;
   logic        reset, start;
   op_e         op;
   logic [31:0] rs1Data, rs2Data;
   logic [4:0]  rdAddr;
   logic        busy, wEn;
   logic [4:0]  wAddr;
   logic [31:0] wData;

   typedef struct {
      string       tag;
      logic [4:0]  addr;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   passed = 0;
   int   c0, c1, dummy;

   mul_div_unit #(.RegisterWidth(W), .NRegisters(32)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .op      (op),
      .rs1Data (rs1Data),
      .rs2Data (rs2Data),
      .rdAddr  (rdAddr),
      .busy    (busy),
      .wEn     (wEn),
      .wAddr   (wAddr),
      .wData   (wData)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual === expected) passed++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
   endtask

   // Monitor: every write strobe pops one expectation; idle cycles must present zeros.
   always @(negedge clk) begin
      if (wEn === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_write_addr", {27'd0, wAddr}, 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check({e.tag, "_addr"}, {27'd0, wAddr}, {27'd0, e.addr});
            check({e.tag, "_data"}, wData, e.data);
            check({e.tag, "_cycle"}, cyc, e.cyc);
         end
      end else begin
         check("idle_wdata", wData, 32'd0);
         check("idle_waddr", {27'd0, wAddr}, 32'd0);
      end
   end

   task automatic wait_idle(input string tag);
      int n = 0;
      @(negedge clk);
      while (busy !== 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (busy !== 1'b0) check({tag, "_idle_timeout"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic issue(input string tag, input op_e o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp_val, input bit special,
                        output int acc_cyc);
      wait_idle(tag);
      start   = 1'b1;
      op      = o;
      rs1Data = a;
      rs2Data = b;
      rdAddr  = rd;
      acc_cyc = cyc + 1;
      sb.push_back('{tag: tag, addr: rd, data: exp_val, cyc: acc_cyc + (special ? SPECIAL_DELTA : W)});
      @(posedge clk);
      #1;
      // Scramble the ports so the unit must rely on its latched copies.
      start   = 1'b0;
      op      = REMU;
      rs1Data = 32'hA5A5_5A5A;
      rs2Data = 32'h1234_5678;
      rdAddr  = 5'd31;
   endtask

   initial begin
      reset   = 1'b1;
      start   = 1'b0;
      op      = MUL;
      rs1Data = '0;
      rs2Data = '0;
      rdAddr  = '0;
      #1 reset = 1'b0;
      #2;
      check("reset_busy",  {31'd0, busy}, 32'd0);
      check("reset_wen",   {31'd0, wEn},  32'd0);
      check("reset_waddr", {27'd0, wAddr}, 32'd0);
      check("reset_wdata", wData, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // Basic multiply with full-latency timing around the DONE cycle.
      issue("mul_7x-3", MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 1'b0, c0);
      while (cyc < c0 + W) @(negedge clk);
      check("mul_done_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      check("mul_after_done_busy", {31'd0, busy}, 32'd0);

      issue("mulh_min",   MULH,   32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 1'b0, dummy);
      issue("mulhu_ones", MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 1'b0, dummy);
      issue("mulhsu_ones",MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, 1'b0, dummy);
      issue("mul_zero_x0",MUL,    32'd0,         32'd12345,     5'd0, 32'd0,         1'b1, dummy);
      issue("div_-7_2",   DIV,    32'hFFFF_FFF9, 32'd2,         5'd4, 32'hFFFF_FFFD, 1'b0, dummy);
      issue("rem_-7_2",   REM,    32'hFFFF_FFF9, 32'd2,         5'd6, 32'hFFFF_FFFF, 1'b0, dummy);
      issue("divu_7_2",   DIVU,   32'd7,         32'd2,         5'd7, 32'd3,         1'b0, dummy);
      issue("remu_7_2",   REMU,   32'd7,         32'd2,         5'd8, 32'd1,         1'b0, dummy);
      issue("div_100_-7", DIV,    32'd100,       32'hFFFF_FFF9, 5'd9, 32'hFFFF_FFF2, 1'b0, dummy);
      issue("rem_100_-7", REM,    32'd100,       32'hFFFF_FFF9, 5'd10, 32'd2,        1'b0, dummy);
      issue("divu_5_0",   DIVU,   32'd5,         32'd0,         5'd11, 32'hFFFF_FFFF, 1'b1, dummy);
      issue("rem_5_0",    REM,    32'd5,         32'd0,         5'd12, 32'd5,         1'b1, dummy);
      issue("div_-7_0",   DIV,    32'hFFFF_FFF9, 32'd0,         5'd13, 32'hFFFF_FFFF, 1'b1, dummy);
      issue("rem_-7_0",   REM,    32'hFFFF_FFF9, 32'd0,         5'd14, 32'hFFFF_FFF9, 1'b1, dummy);
      issue("div_ovf",    DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1'b1, dummy);
      issue("rem_ovf",    REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0,         1'b1, dummy);
      issue("divu_no_ovf",DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0,         1'b0, dummy);

      // Reset in the middle of a divide: outputs clear at once and the write is dropped.
      issue("div_aborted", DIV, 32'd100, 32'd7, 5'd18, 32'd14, 1'b0, c0);
      repeat (9) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check("abort_busy",  {31'd0, busy}, 32'd0);
      check("abort_wen",   {31'd0, wEn},  32'd0);
      check("abort_wdata", wData, 32'd0);
      sb.delete();
      @(negedge clk);
      reset = 1'b1;
      issue("mul_3x4", MUL, 32'd3, 32'd4, 5'd19, 32'd12, 1'b0, dummy);

      // start held through RUN and DONE: second op is accepted in the first IDLE cycle.
      wait_idle("hold");
      start   = 1'b1;
      op      = MUL;
      rs1Data = 32'd3;
      rs2Data = 32'd5;
      rdAddr  = 5'd20;
      c1      = cyc + 1;
      sb.push_back('{tag: "hold_first", addr: 5'd20, data: 32'd15, cyc: c1 + W});
      @(posedge clk);
      #1;
      op      = MULHU;
      rs1Data = 32'hFFFF_FFFF;
      rs2Data = 32'd2;
      rdAddr  = 5'd21;
      sb.push_back('{tag: "hold_second", addr: 5'd21, data: 32'd1, cyc: c1 + 2 * W + 2});
      while (cyc < c1 + W + 2) @(negedge clk);
      check("hold_second_accepted", {31'd0, busy}, 32'd1);
      start = 1'b0;

      begin
         int n = 0;
         while (sb.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
         end
      end
      check("scoreboard_drained", sb.size(), 32'd0);
      repeat (4) @(negedge clk);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
